// File: rtl/video_mode_detect_if.sv
// Doubled video stream from the scan doubler into the mode detector, plus
// the measured mode/status it reports to the OSD/IO controller.
interface video_mode_detect_if #(
  parameter int HCNT_WIDTH = 11,
  parameter int VCNT_WIDTH = 10
);
  logic                  ce_pix;
  logic                  hs_in;
  logic                  vs_in;
  logic [HCNT_WIDTH-1:0] h_total;
  logic [HCNT_WIDTH-1:0] h_sync;
  logic                  hs_pol;
  logic [VCNT_WIDTH-1:0] v_total;
  logic [VCNT_WIDTH-1:0] v_sync;
  logic                  vs_pol;
  logic                  locked;
  logic                  changed;

  modport master (
    output ce_pix, hs_in, vs_in,
    input  h_total, h_sync, hs_pol, v_total, v_sync, vs_pol, locked, changed
  );

  modport slave (
    input  ce_pix, hs_in, vs_in,
    output h_total, h_sync, hs_pol, v_total, v_sync, vs_pol, locked, changed
  );
endinterface

// File: rtl/video_mode_detect.sv
// Measures line/frame timing of the doubled video stream and reports a mode
// once it has repeated for STABLE_FRAMES frames, pulsing changed on each lock.
module video_mode_detect #(
  parameter int HCNT_WIDTH    = 11,
  parameter int VCNT_WIDTH    = 10,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  video_mode_detect_if.slave  vid
);

  localparam logic [HCNT_WIDTH-1:0] HMAX = '1;
  localparam logic [VCNT_WIDTH-1:0] VMAX = '1;

  typedef struct packed {
    logic [HCNT_WIDTH-1:0] len;
    logic [HCNT_WIDTH-1:0] hsync;
    logic                  hpol;
    logic [VCNT_WIDTH-1:0] lines;
    logic [VCNT_WIDTH-1:0] vsync;
    logic                  vpol;
  } mode_t;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t                state, state_n;
  logic                  hs_q, vs_q;
  logic [HCNT_WIDTH-1:0] hcnt, hlow;
  logic [VCNT_WIDTH-1:0] lcnt, vlow, lcnt_next, vlow_next;
  logic [HCNT_WIDTH-1:0] line_len, line_sync;
  logic                  line_pol;
  logic [HCNT_WIDTH-1:0] new_len, new_low, new_high, new_sync;
  logic                  new_pol;
  logic [VCNT_WIDTH-1:0] vhigh;
  logic                  line_edge, frame_edge, timeout;
  mode_t                 cand, stored, stored_n, outs, outs_n;
  logic [3:0]            match_cnt, match_cnt_n;
  logic                  locked, locked_n, changed_n;

  assign line_edge  = vid.ce_pix & hs_q & ~vid.hs_in;
  assign frame_edge = vid.ce_pix & vs_q & ~vid.vs_in;

  // The tick that starts a line is always a low tick, hence the +1 on hlow.
  assign new_len  = hcnt + HCNT_WIDTH'(1);
  assign new_low  = hlow + HCNT_WIDTH'(1);
  assign new_high = new_len - new_low;
  assign new_pol  = (new_low <= new_high);
  assign new_sync = new_pol ? new_low : new_high;

  assign lcnt_next = (line_edge && lcnt != VMAX) ? lcnt + VCNT_WIDTH'(1) : lcnt;
  assign vlow_next = (line_edge && lcnt != VMAX && !vid.vs_in) ? vlow + VCNT_WIDTH'(1) : vlow;
  assign vhigh     = lcnt_next - vlow_next;

  // A line edge on the frame-edge tick belongs to the frame that is ending.
  always_comb begin
    cand       = '0;
    cand.len   = line_edge ? new_len  : line_len;
    cand.hsync = line_edge ? new_sync : line_sync;
    cand.hpol  = line_edge ? new_pol  : line_pol;
    cand.lines = lcnt_next;
    cand.vpol  = (vlow_next <= vhigh);
    cand.vsync = cand.vpol ? vlow_next : vhigh;
  end

  assign timeout = (vid.ce_pix && !line_edge && hcnt >= HMAX - HCNT_WIDTH'(1)) ||
                   (line_edge && !frame_edge && lcnt_next == VMAX);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      hcnt      <= '0;
      hlow      <= '0;
      lcnt      <= '0;
      vlow      <= '0;
      line_len  <= '0;
      line_sync <= '0;
      line_pol  <= 1'b0;
    end else if (vid.ce_pix) begin
      hs_q <= vid.hs_in;
      vs_q <= vid.vs_in;
      if (line_edge) begin
        hcnt      <= '0;
        hlow      <= '0;
        line_len  <= new_len;
        line_sync <= new_sync;
        line_pol  <= new_pol;
      end else if (hcnt != HMAX) begin
        hcnt <= hcnt + HCNT_WIDTH'(1);
        if (!vid.hs_in) hlow <= hlow + HCNT_WIDTH'(1);
      end
      if (frame_edge) begin
        lcnt <= '0;
        vlow <= '0;
      end else begin
        lcnt <= lcnt_next;
        vlow <= vlow_next;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      stored      <= '0;
      match_cnt   <= '0;
      outs        <= '0;
      locked      <= 1'b0;
      vid.changed <= 1'b0;
    end else begin
      state       <= state_n;
      stored      <= stored_n;
      match_cnt   <= match_cnt_n;
      outs        <= outs_n;
      locked      <= locked_n;
      vid.changed <= changed_n;
    end
  end

  always_comb begin
    state_n     = state;
    stored_n    = stored;
    match_cnt_n = match_cnt;
    outs_n      = outs;
    locked_n    = locked;
    changed_n   = 1'b0;
    if (timeout) begin
      state_n  = SEARCH;
      locked_n = 1'b0;
    end else if (frame_edge) begin
      unique case (state)
        SEARCH, MEASURE: begin
          if (state == MEASURE && cand == stored) begin
            if (match_cnt != 4'hF) match_cnt_n = match_cnt + 4'd1;
          end else begin
            stored_n    = cand;
            match_cnt_n = 4'd1;
          end
          state_n = MEASURE;
          if (match_cnt_n >= 4'(STABLE_FRAMES)) begin
            outs_n    = cand;
            locked_n  = 1'b1;
            changed_n = 1'b1;
            state_n   = LOCKED;
          end
        end
        LOCKED: begin
          if (cand != outs) begin
            locked_n    = 1'b0;
            stored_n    = cand;
            match_cnt_n = 4'd1;
            state_n     = MEASURE;
          end
        end
        default: state_n = SEARCH;
      endcase
    end
  end

  assign vid.h_total = outs.len;
  assign vid.h_sync  = outs.hsync;
  assign vid.hs_pol  = outs.hpol;
  assign vid.v_total = outs.lines;
  assign vid.v_sync  = outs.vsync;
  assign vid.vs_pol  = outs.vpol;
  assign vid.locked  = locked;

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed bench for video_mode_detect: small synthetic video modes with
// hand-computed expected mode tuples, lock latency, timeout and reset.
module tb_video_mode_detect;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   chg_cnt = 0;

  always #5 clk = ~clk;

  video_mode_detect_if #(.HCNT_WIDTH(11), .VCNT_WIDTH(10)) vif ();

  video_mode_detect #(
    .HCNT_WIDTH(11),
    .VCNT_WIDTH(10),
    .STABLE_FRAMES(3)
  ) dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .vid(vif)
  );

  typedef struct {
    int hlen;
    int hsw;
    bit hlo;
    int lines;
    int vsw;
    bit vlo;
    int div;
  } vmode_t;

  always @(negedge clk) if (vif.changed) chg_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One pixel tick: ce_pix high for one clock out of div; returns #1 after it.
  task automatic tick(input logic h, input logic v, input int div);
    @(negedge clk);
    vif.hs_in  = h;
    vif.vs_in  = v;
    vif.ce_pix = 1'b1;
    @(posedge clk);
    for (int i = 1; i < div; i++) begin
      @(negedge clk);
      vif.ce_pix = 1'b0;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic pix(input vmode_t m, input int l, input int t);
    logic h, v;
    h = (t < m.hsw) ? !m.hlo : m.hlo;
    v = (l < m.vsw) ? !m.vlo : m.vlo;
    tick(h, v, m.div);
  endtask

  task automatic send_frame(input vmode_t m, input int skip);
    for (int l = 0; l < m.lines; l++)
      for (int t = 0; t < m.hlen; t++)
        if (l * m.hlen + t >= skip) pix(m, l, t);
  endtask

  task automatic check_mode(input string tag, input int ht, input int hs, input int hp,
                            input int vt, input int vs, input int vp);
    check({tag, "_h_total"}, 32'(vif.h_total), 32'(ht));
    check({tag, "_h_sync"},  32'(vif.h_sync),  32'(hs));
    check({tag, "_hs_pol"},  32'(vif.hs_pol),  32'(hp));
    check({tag, "_v_total"}, 32'(vif.v_total), 32'(vt));
    check({tag, "_v_sync"},  32'(vif.v_sync),  32'(vs));
    check({tag, "_vs_pol"},  32'(vif.vs_pol),  32'(vp));
    check({tag, "_locked"},  32'(vif.locked),  32'd1);
  endtask

  vmode_t ma, mb, mc, md;

  initial begin
    ma = '{hlen: 64,   hsw: 8,   hlo: 1'b1, lines: 20, vsw: 2, vlo: 1'b1, div: 1};
    mb = '{hlen: 64,   hsw: 8,   hlo: 1'b0, lines: 20, vsw: 2, vlo: 1'b0, div: 1};
    mc = '{hlen: 64,   hsw: 8,   hlo: 1'b1, lines: 31, vsw: 2, vlo: 1'b1, div: 1};
    md = '{hlen: 1024, hsw: 100, hlo: 1'b1, lines: 3,  vsw: 1, vlo: 1'b1, div: 2};
    vif.ce_pix = 1'b0;
    vif.hs_in  = 1'b1;
    vif.vs_in  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_h_total", 32'(vif.h_total), 0);
    check("rst_h_sync",  32'(vif.h_sync),  0);
    check("rst_hs_pol",  32'(vif.hs_pol),  0);
    check("rst_v_total", 32'(vif.v_total), 0);
    check("rst_v_sync",  32'(vif.v_sync),  0);
    check("rst_vs_pol",  32'(vif.vs_pol),  0);
    check("rst_locked",  32'(vif.locked),  0);
    check("rst_changed", 32'(vif.changed), 0);

    reset_n = 1'b1;
    repeat (10) tick(1'b1, 1'b1, 1);

    // Active-low mode: lock exactly at the frame edge that starts frame 4.
    repeat (3) send_frame(ma, 0);
    check("a_prelock", 32'(vif.locked), 0);
    pix(ma, 0, 0);
    check("a_lock_lat", 32'(vif.locked), 1);
    check("a_chg_lat",  32'(vif.changed), 1);
    send_frame(ma, 1);
    check_mode("a", 64, 8, 1, 20, 2, 1);
    check("a_chg_cnt", 32'(chg_cnt), 1);

    // Line count change: unlock at first differing frame edge, values held.
    send_frame(mc, 0);
    pix(mc, 0, 0);
    check("c_unlock",       32'(vif.locked),  0);
    check("c_held_v_total", 32'(vif.v_total), 20);
    send_frame(mc, 1);
    send_frame(mc, 0);
    pix(mc, 0, 0);
    send_frame(mc, 1);
    check_mode("c", 64, 8, 1, 31, 2, 1);
    check("c_chg_cnt", 32'(chg_cnt), 2);

    // Positive syncs.
    repeat (5) send_frame(mb, 0);
    check_mode("b", 64, 8, 0, 20, 2, 0);
    check("b_chg_cnt", 32'(chg_cnt), 3);

    // hs stops: last fall 56 ticks before frame end, timeout 2047 ticks after it.
    repeat (1991) tick(1'b1, 1'b1, 1);
    check("to_before", 32'(vif.locked), 1);
    tick(1'b1, 1'b1, 1);
    check("to_after",     32'(vif.locked),  0);
    check("to_held_htot", 32'(vif.h_total), 64);
    check("to_chg_cnt",   32'(chg_cnt),     3);

    repeat (5) send_frame(ma, 0);
    check_mode("relock", 64, 8, 1, 20, 2, 1);
    check("relock_chg_cnt", 32'(chg_cnt), 4);

    // ce_pix every second clock: totals are in ticks.
    repeat (5) send_frame(md, 0);
    check_mode("d", 1024, 100, 1, 3, 1, 1);
    check("d_chg_cnt", 32'(chg_cnt), 5);

    // Asynchronous reset in the middle of a clock period.
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_locked",  32'(vif.locked),  0);
    check("arst_h_total", 32'(vif.h_total), 0);
    check("arst_v_total", 32'(vif.v_total), 0);
    check("arst_hs_pol",  32'(vif.hs_pol),  0);
    check("arst_v_sync",  32'(vif.v_sync),  0);
    repeat (4) @(posedge clk);
    #1;
    check("arst_changed", 32'(vif.changed), 0);
    check("arst_chg_cnt", 32'(chg_cnt),     5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
